// File: rtl/root_stage_sequencer_if.sv
// Hub FIFO link between the root stage sequencer (master) and the hub arbitration toward the leaves (slave).
interface root_stage_sequencer_if #(
  parameter int HUB_FIFO_WIDTH = 16
);
  logic [HUB_FIFO_WIDTH-1:0] hub_fifo_out_data;
  logic                      hub_fifo_out_valid;
  logic                      hub_fifo_out_ready;
  logic [HUB_FIFO_WIDTH-1:0] hub_fifo_in_data;
  logic                      hub_fifo_in_valid;
  logic                      hub_fifo_in_ready;

  modport master (
    output hub_fifo_out_data, output hub_fifo_out_valid, input hub_fifo_out_ready,
    input  hub_fifo_in_data,  input  hub_fifo_in_valid,  output hub_fifo_in_ready
  );

  modport slave (
    input  hub_fifo_out_data, input  hub_fifo_out_valid, output hub_fifo_out_ready,
    output hub_fifo_in_data,  output hub_fifo_in_valid,  input  hub_fifo_in_ready
  );
endinterface

// File: rtl/root_stage_sequencer.sv
// Root-side stage sequencer: broadcasts stage commands, polls leaf status and iterates grow/merge.
// Optional macro STATUS_TIMEOUT_EN adds a POLL_TIMEOUT bound on the status poll.
module root_stage_sequencer #(
  parameter int LEAF_COUNT              = 2,
  parameter int FPGAID_WIDTH            = 2,
  parameter int HUB_FIFO_WIDTH          = 16,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 20,
  parameter int LOAD_CYCLES             = 12,
  parameter int GROW_CYCLES             = 2
`ifdef STATUS_TIMEOUT_EN
  , parameter int POLL_TIMEOUT          = 1024
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  output logic [2:0]                         stage,
  output logic                               result_valid,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [31:0]                        cycle_counter,
  output logic                               deadlock,
  output logic                               busy,
  root_stage_sequencer_if.master             hub
);

  localparam int W     = HUB_FIFO_WIDTH;
  localparam int IW    = ITERATION_COUNTER_WIDTH;
  localparam int CNT_W = 16;
  localparam logic [1:0] MSG_CMD = 2'd0;
  localparam logic [1:0] MSG_REQ = 2'd1;
  localparam logic [1:0] MSG_RSP = 2'd2;
  localparam logic [FPGAID_WIDTH-1:0] LAST_LEAF  = FPGAID_WIDTH'(LEAF_COUNT);
  localparam logic [FPGAID_WIDTH-1:0] FIRST_LEAF = FPGAID_WIDTH'(1);
  localparam logic [IW:0]             MAX_ITER   = (IW + 1)'(MAX_ITERATIONS);

  typedef enum logic [3:0] {
    S_IDLE, S_BCAST_LOAD, S_WAIT_LOAD, S_BCAST_GROW, S_WAIT_GROW,
    S_BCAST_MERGE, S_POLL_SEND, S_POLL_WAIT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [FPGAID_WIDTH-1:0] leaf_q, leaf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LEAF_COUNT-1:0]   responded_q, responded_d;
  logic                    flying_q, flying_d;
  logic                    odd_q, odd_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic [31:0]             cycle_q, cycle_d;
  logic                    deadlock_q, deadlock_d;
  logic                    result_q, result_d;
  logic                    in_ready_q;

  logic                    bcast;
  logic [1:0]              bcast_kind;
  logic [2:0]              bcast_code;
  state_t                  bcast_after;
  logic [2:0]              stage_w;
  logic                    out_valid_w;
  logic [W-1:0]            out_data_w;
  logic [1:0]              rx_kind;
  logic [FPGAID_WIDTH-1:0] rx_id;
  logic                    rx_ok;

  function automatic logic [W-1:0] make_msg(input logic [1:0] kind,
                                            input logic [FPGAID_WIDTH-1:0] id,
                                            input logic [2:0] code);
    logic [W-1:0] m;
    m = '0;
    m[W-1 -: 2] = kind;
    m[W-3 -: FPGAID_WIDTH] = id;
    m[2:0] = code;
    return m;
  endfunction

  assign rx_kind = hub.hub_fifo_in_data[W-1 -: 2];
  assign rx_id   = hub.hub_fifo_in_data[W-3 -: FPGAID_WIDTH];
  assign rx_ok   = hub.hub_fifo_in_valid && in_ready_q && (rx_kind == MSG_RSP) &&
                   (rx_id != '0) && (rx_id <= LAST_LEAF);

  always_comb begin
    state_d     = state_q;
    leaf_d      = leaf_q;
    cnt_d       = cnt_q;
    responded_d = responded_q;
    flying_d    = flying_q;
    odd_d       = odd_q;
    iter_d      = iter_q;
    cycle_d     = cycle_q;
    deadlock_d  = deadlock_q;
    result_d    = 1'b0;
    bcast       = 1'b0;
    bcast_kind  = MSG_CMD;
    bcast_code  = 3'd0;
    bcast_after = state_q;
    stage_w     = 3'd0;
    out_valid_w = 1'b0;
    out_data_w  = '0;

    if (state_q != S_IDLE && cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (new_round_start) begin
          iter_d     = '0;
          cycle_d    = '0;
          deadlock_d = 1'b0;
          state_d    = S_BCAST_LOAD;
        end
      end
      S_BCAST_LOAD: begin
        stage_w = 3'd1; bcast = 1'b1; bcast_code = 3'd1; bcast_after = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        stage_w = 3'd1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) state_d = S_BCAST_GROW;
      end
      S_BCAST_GROW: begin
        stage_w = 3'd2; bcast = 1'b1; bcast_code = 3'd2; bcast_after = S_WAIT_GROW;
      end
      S_WAIT_GROW: begin
        stage_w = 3'd2;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(GROW_CYCLES - 1)) state_d = S_BCAST_MERGE;
      end
      S_BCAST_MERGE: begin
        stage_w = 3'd3; bcast = 1'b1; bcast_code = 3'd3; bcast_after = S_POLL_SEND;
      end
      S_POLL_SEND: begin
        stage_w     = 3'd3;
        responded_d = '0;
        flying_d    = 1'b0;
        odd_d       = 1'b0;
        bcast = 1'b1; bcast_kind = MSG_REQ; bcast_after = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        stage_w = 3'd3;
        if (rx_ok) begin
          for (int i = 0; i < LEAF_COUNT; i++)
            if (rx_id == FPGAID_WIDTH'(i + 1)) responded_d[i] = 1'b1;
          flying_d = flying_q | hub.hub_fifo_in_data[1];
          odd_d    = odd_q | hub.hub_fifo_in_data[0];
        end
        // Decision uses the registered bitmaps, i.e. the cycle after the last response.
        if (&responded_q) begin
          if (flying_q) begin
            state_d = S_POLL_SEND;
          end else if (odd_q) begin
            iter_d = (iter_q == '1) ? iter_q : iter_q + 1'b1;
            if ({1'b0, iter_d} < MAX_ITER) begin
              state_d = S_BCAST_GROW;
            end else begin
              deadlock_d = 1'b1;
              state_d    = S_DONE;
            end
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef STATUS_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(POLL_TIMEOUT - 1)) begin
            deadlock_d = 1'b1;
            state_d    = S_DONE;
          end
        end
`endif
      end
      S_DONE: begin
        stage_w = 3'd4; bcast = 1'b1; bcast_code = 3'd4; bcast_after = S_IDLE;
        if (hub.hub_fifo_out_ready && leaf_q == LAST_LEAF) result_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Broadcasts walk leaf IDs upward, advancing only on an accepted transfer.
    if (bcast) begin
      out_valid_w = 1'b1;
      out_data_w  = make_msg(bcast_kind, leaf_q, bcast_code);
      if (hub.hub_fifo_out_ready) begin
        if (leaf_q == LAST_LEAF) begin
          leaf_d  = FIRST_LEAF;
          cnt_d   = '0;
          state_d = bcast_after;
        end else begin
          leaf_d = leaf_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      leaf_q      <= FIRST_LEAF;
      cnt_q       <= '0;
      responded_q <= '0;
      flying_q    <= 1'b0;
      odd_q       <= 1'b0;
      iter_q      <= '0;
      cycle_q     <= '0;
      deadlock_q  <= 1'b0;
      result_q    <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      leaf_q      <= leaf_d;
      cnt_q       <= cnt_d;
      responded_q <= responded_d;
      flying_q    <= flying_d;
      odd_q       <= odd_d;
      iter_q      <= iter_d;
      cycle_q     <= cycle_d;
      deadlock_q  <= deadlock_d;
      result_q    <= result_d;
      in_ready_q  <= 1'b1;
    end
  end

  assign stage                  = stage_w;
  assign result_valid           = result_q;
  assign iteration_counter      = iter_q;
  assign cycle_counter          = cycle_q;
  assign deadlock               = deadlock_q;
  assign busy                   = (state_q != S_IDLE);
  assign hub.hub_fifo_out_valid = out_valid_w;
  assign hub.hub_fifo_out_data  = out_data_w;
  assign hub.hub_fifo_in_ready  = in_ready_q;

endmodule

// File: tb/tb_root_stage_sequencer.sv
// Randomized scoreboard bench for root_stage_sequencer: a leaf model answers polls and a
// round-level reference model predicts every hub message and each round result.
module tb_root_stage_sequencer;

  localparam int L     = 2;
  localparam int W     = 16;
  localparam int IW    = 8;
  localparam int MAXIT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_round_start = 1'b0;
  logic [2:0]    stage;
  logic          result_valid;
  logic [IW-1:0] iteration_counter;
  logic [31:0]   cycle_counter;
  logic          deadlock;
  logic          busy;

  root_stage_sequencer_if #(.HUB_FIFO_WIDTH(W)) hub ();

  root_stage_sequencer #(
    .LEAF_COUNT(L), .FPGAID_WIDTH(2), .HUB_FIFO_WIDTH(W), .ITERATION_COUNTER_WIDTH(IW),
    .MAX_ITERATIONS(MAXIT), .LOAD_CYCLES(12), .GROW_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .new_round_start(new_round_start), .stage(stage),
    .result_valid(result_valid), .iteration_counter(iteration_counter),
    .cycle_counter(cycle_counter), .deadlock(deadlock), .busy(busy), .hub(hub)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int req_seen = 0;
  int results_seen = 0;
  int last_exp_cycles = 0;
  bit mon_en = 1'b0;
  bit last_dl = 1'b0;

  logic [W-1:0] exp_msg_q[$];
  int           exp_iter_q[$];
  bit           exp_dl_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] cmdWord(input int code, input int id);
    return {2'd0, 2'(id), 9'd0, 3'(code)};
  endfunction

  function automatic logic [W-1:0] reqWord(input int id);
    return {2'd1, 2'(id), 12'd0};
  endfunction

  function automatic logic [W-1:0] rspWord(input int kind, input int id, input logic [1:0] flags);
    return {2'(kind), 2'(id), 10'd0, flags};
  endfunction

  task automatic pushCmds(input int code);
    for (int id = 1; id <= L; id++) exp_msg_q.push_back(cmdWord(code, id));
  endtask

  task automatic pushReqs();
    for (int id = 1; id <= L; id++) exp_msg_q.push_back(reqWord(id));
  endtask

  // Ready driver: random backpressure with occasional 5-cycle stalls, changed just after posedge.
  int stall_left = 0;
  always @(posedge clk) begin
    int r;
    #2;
    r = int'($urandom_range(15, 0));
    if (stall_left > 0) begin
      hub.hub_fifo_out_ready = 1'b0;
      stall_left--;
    end else if (r == 0) begin
      hub.hub_fifo_out_ready = 1'b0;
      stall_left = 4;
    end else begin
      hub.hub_fifo_out_ready = (r >= 4);
    end
  end

  // Monitor: pops the scoreboard on every hub transfer and every result pulse.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (mon_en) begin
      if (prev_stall) begin
        checkOutput("hold_valid", {31'd0, hub.hub_fifo_out_valid}, 32'd1);
        checkOutput("hold_data", {16'd0, hub.hub_fifo_out_data}, {16'd0, prev_data});
      end
      if (hub.hub_fifo_out_valid && hub.hub_fifo_out_ready) begin
        if (exp_msg_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_msg: got 0x%0h, expected no transfer", hub.hub_fifo_out_data);
        end else begin
          exp = exp_msg_q.pop_front();
          checkOutput("msg", {16'd0, hub.hub_fifo_out_data}, {16'd0, exp});
          checkOutput("stage", {29'd0, stage}, (exp[15:14] == 2'd0) ? {29'd0, exp[2:0]} : 32'd3);
          checkOutput("busy", {31'd0, busy}, 32'd1);
          if (exp[15:14] == 2'd1) req_seen++;
        end
      end
      if (result_valid) begin
        if (exp_iter_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_result: got result_valid=1, expected 0");
        end else begin
          last_exp_cycles = cyc - start_cyc;
          checkOutput("result_iter", {24'd0, iteration_counter}, 32'(exp_iter_q.pop_front()));
          checkOutput("result_deadlock", {31'd0, deadlock}, {31'd0, exp_dl_q.pop_front()});
          checkOutput("result_cycles", cycle_counter, 32'(last_exp_cycles));
          checkOutput("result_msgs_drained", 32'(exp_msg_q.size()), 32'd0);
          results_seen++;
        end
      end
      prev_stall = hub.hub_fifo_out_valid && !hub.hub_fifo_out_ready;
      prev_data  = hub.hub_fifo_out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic sendRsp(input logic [W-1:0] d);
    hub.hub_fifo_in_data  = d;
    hub.hub_fifo_in_valid = 1'b1;
    @(negedge clk);
    hub.hub_fifo_in_valid = 1'b0;
    hub.hub_fifo_in_data  = '0;
  endtask

  function automatic logic [1:0] chooseFlags(input int mode, input int poll, input int id);
    case (mode)
      0: return 2'b00;
      1: return (poll == 0 && id == 2) ? 2'b01 : 2'b00;
      2: return (poll == 0 && id == 1) ? 2'b10 : 2'b00;
      3: return 2'b01;
      default: begin
        if (poll >= 6) return 2'b00;
        return {($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0)};
      end
    endcase
  endfunction

  task automatic pulseStart();
    new_round_start = 1'b1;
    @(negedge clk);
    new_round_start = 1'b0;
  endtask

  // One decoding round; returns after the result pulse (or a FAIL on an expired bound).
  task automatic applyStimulus(input int mode, input bit abort_in_poll);
    int iter, poll, target, res_target, guard, tmp, j;
    bit done, any_fly, any_odd, dl;
    logic [1:0] flags [L+1];
    int order[$];
    logic [W-1:0] items[$];

    checkOutput("deadlock_held", {31'd0, deadlock}, {31'd0, last_dl});
    pushCmds(1); pushCmds(2); pushCmds(3); pushReqs();
    target = req_seen + L;
    res_target = results_seen + 1;
    new_round_start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    new_round_start = 1'b0;
    iter = 0; poll = 0; done = 1'b0; dl = 1'b0;

    while (!done) begin
      guard = 0;
      while (req_seen < target && guard < 2000) begin @(negedge clk); guard++; end
      if (guard >= 2000) begin
        checks++; errors++;
        $display("[TB] FAIL poll_timeout: got %0d requests, expected %0d", req_seen, target);
        return;
      end
      @(negedge clk);
      if (abort_in_poll) begin
        mon_en = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_stage", {29'd0, stage}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_out_valid", {31'd0, hub.hub_fifo_out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, hub.hub_fifo_in_ready}, 32'd0);
        checkOutput("abort_cycles", cycle_counter, 32'd0);
        checkOutput("abort_iter", {24'd0, iteration_counter}, 32'd0);
        exp_msg_q.delete(); exp_iter_q.delete(); exp_dl_q.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        last_dl = 1'b0;
        return;
      end

      any_fly = 1'b0; any_odd = 1'b0;
      for (int id = 1; id <= L; id++) flags[id] = chooseFlags(mode, poll, id);
      order.delete();
      if (mode == 1 && poll == 0) begin
        order.push_back(2); order.push_back(1);
      end else begin
        for (int id = 1; id <= L; id++) order.push_back(id);
        for (int i = L - 1; i > 0; i--) begin
          j = int'($urandom_range(i, 0));
          tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
      end
      items.delete();
      for (int k = 0; k < L; k++) begin
        items.push_back(rspWord(2, order[k], flags[order[k]]));
        any_fly |= flags[order[k]][1];
        any_odd |= flags[order[k]][0];
        if (k < L - 1 && (mode == 2 || (mode >= 4 && $urandom_range(2, 0) == 0))) begin
          items.push_back(rspWord(2, 0, 2'b11));
          items.push_back(rspWord(2, 3, 2'b11));
          items.push_back(rspWord(0, order[k], 2'b11));
          items.push_back(rspWord(3, order[k + 1], 2'b11));
        end
        if (k < L - 1 && mode >= 4 && $urandom_range(3, 0) == 0) begin
          logic [1:0] df;
          df = (poll >= 6) ? 2'b00 : {($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0)};
          items.push_back(rspWord(2, order[k], df));
          any_fly |= df[1];
          any_odd |= df[0];
        end
      end

      if (any_fly) begin
        pushReqs();
      end else if (any_odd) begin
        iter++;
        if (iter < MAXIT) begin
          pushCmds(2); pushCmds(3); pushReqs();
        end else begin
          dl = 1'b1;
          pushCmds(4); exp_iter_q.push_back(iter); exp_dl_q.push_back(1'b1); done = 1'b1;
        end
      end else begin
        pushCmds(4); exp_iter_q.push_back(iter); exp_dl_q.push_back(1'b0); done = 1'b1;
      end
      if (!done) target += L;
      poll++;

      if (mode >= 4) pulseStart();
      foreach (items[i]) begin
        sendRsp(items[i]);
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
    end

    guard = 0;
    while (results_seen < res_target && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("[TB] FAIL result_timeout: got %0d results, expected %0d", results_seen, res_target);
      return;
    end
    repeat (3) @(negedge clk);
    checkOutput("idle_stage", {29'd0, stage}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("cycles_held", cycle_counter, 32'(last_exp_cycles));
    checkOutput("deadlock_after", {31'd0, deadlock}, {31'd0, dl});
    last_dl = dl;
  endtask

  initial begin
    hub.hub_fifo_out_ready = 1'b1;
    hub.hub_fifo_in_valid  = 1'b1;
    hub.hub_fifo_in_data   = 16'h8003;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_stage", {29'd0, stage}, 32'd0);
    checkOutput("rst_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_iter", {24'd0, iteration_counter}, 32'd0);
    checkOutput("rst_cycles", cycle_counter, 32'd0);
    checkOutput("rst_deadlock", {31'd0, deadlock}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, hub.hub_fifo_out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, hub.hub_fifo_out_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, hub.hub_fifo_in_ready}, 32'd0);
    hub.hub_fifo_in_valid = 1'b0;
    hub.hub_fifo_in_data  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("in_ready_up", {31'd0, hub.hub_fifo_in_ready}, 32'd1);
    mon_en = 1'b1;

    $display("[TB] directed rounds");
    applyStimulus(0, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b0);
    $display("[TB] random rounds");
    for (int r = 0; r < 12; r++) applyStimulus(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("[TB] FAIL watchdog: got no completion after 60000 cycles, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/root_stage_sequencer.md
Name: root_stage_sequencer

Overview:
- Root-FPGA counterpart of the leaf-side dummy stage controller: the initiator that drives every leaf's decoding stages over the hub FIFO link and collects their status.
- Broadcasts stage commands to leaves 1..LEAF_COUNT and polls each leaf for {has_message_flying, has_odd_clusters}.
- Sequences grow/merge iterations until all clusters are even or the iteration limit is reached.
- Sits on the root FPGA between the round-start trigger and the hub FIFO arbitration toward the leaves.

Parameters:
- LEAF_COUNT, 2, number of leaf FPGAs; leaf IDs are 1..LEAF_COUNT, root is ID 0.
- FPGAID_WIDTH, 2, width of the ID field; must satisfy LEAF_COUNT < 2**FPGAID_WIDTH.
- HUB_FIFO_WIDTH, 16, hub message width.
- ITERATION_COUNTER_WIDTH, 8, width of iteration_counter.
- MAX_ITERATIONS, 20, grow/merge iteration limit before deadlock.
- LOAD_CYCLES, 12, wait cycles after the LOADING broadcast (covers the leaf error-update delay of 10 cycles).
- GROW_CYCLES, 2, wait cycles after the GROW broadcast before MERGE is broadcast.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- new_round_start  in  1  one-cycle pulse that starts a decoding round
- stage  out  3  current stage: IDLE=0, LOADING=1, GROW=2, MERGE=3, RESULT=4
- result_valid  out  1  one-cycle pulse at round end
- iteration_counter  out  ITERATION_COUNTER_WIDTH  completed grow/merge iterations
- cycle_counter  out  32  cycles from round start until result_valid
- deadlock  out  1  round ended on iteration limit (or timeout); held until the next round
- hub_fifo_out_data  out  HUB_FIFO_WIDTH  root->leaf message
- hub_fifo_out_valid  out  1
- hub_fifo_out_ready  in  1
- hub_fifo_in_data  in  HUB_FIFO_WIDTH  leaf->root message
- hub_fifo_in_valid  in  1
- hub_fifo_in_ready  out  1  constant 1 when not in reset
- busy  out  1  high in any state except IDLE

Behaviour:
- Message format:
  - [W-1:W-2] type: 0=STAGE_CMD, 1=STATUS_REQ, 2=STATUS_RSP, 3=reserved.
  - [W-3:W-2-FPGAID_WIDTH] leaf ID (destination on output, source on input).
  - STAGE_CMD [2:0] = stage code.
  - STATUS_RSP [1]=flying, [0]=odd.
  - All other bits are 0 on transmit and ignored on receive.
- Reset (reset==0 at posedge): state IDLE; stage=0, result_valid=0, iteration_counter=0, cycle_counter=0, deadlock=0, hub_fifo_out_valid=0, hub_fifo_out_data=0, busy=0, hub_fifo_in_ready=0; response bitmaps cleared. Reset mid-round aborts any pending send.
- Send rule:
  - A message is transferred on a cycle with out_valid && out_ready.
  - Data and valid are held stable while ready is low.
  - Broadcasts send to leaf IDs in ascending order, one per transfer.
  - Next message can be presented the cycle after a transfer.
- FSM:
  - IDLE: on new_round_start, clear iteration_counter, cycle_counter and deadlock; go to BCAST_LOAD.
  - BCAST_LOAD: stage=1; send STAGE_CMD(1) to all leaves; go to WAIT_LOAD for LOAD_CYCLES cycles.
  - BCAST_GROW: stage=2; send STAGE_CMD(2) to all leaves; go to WAIT_GROW for GROW_CYCLES cycles.
  - BCAST_MERGE: stage=3; send STAGE_CMD(3) to all leaves; go to POLL_SEND.
  - POLL_SEND: clear the responded/flying/odd bitmaps; send STATUS_REQ to all leaves; go to POLL_WAIT.
  - POLL_WAIT: accept STATUS_RSP in any order. Set responded[id] and OR the flags into the flying/odd accumulators.
    - Duplicate responses: flags still ORed in.
    - Responses with id 0, id > LEAF_COUNT, or a non-RSP type are dropped.
    - Responses arriving in any other state are dropped.
    - When all responded bits are set (evaluated the cycle after the last accepted response):
      - any flying -> POLL_SEND;
      - else any odd -> iteration_counter+1, then GROW if the new value < MAX_ITERATIONS, else deadlock=1 and go to DONE;
      - else DONE.
  - DONE: stage=4; send STAGE_CMD(4) to all leaves; pulse result_valid for one cycle; go to IDLE (stage=0).
- new_round_start outside IDLE is ignored.
- cycle_counter increments every cycle while busy, saturates at 2^32-1, and holds its value after result_valid until the next round.
- iteration_counter saturates at its maximum value.

Optional Feature:
- Macro STATUS_TIMEOUT_EN.
- When defined:
  - Parameter POLL_TIMEOUT (default 1024) is added.
  - A counter runs in POLL_WAIT and resets on entry.
  - If it reaches POLL_TIMEOUT before all leaves respond: deadlock=1, go to DONE.
- When undefined: POLL_WAIT waits indefinitely; no timeout logic is built.

Test Plan:
- Reset held low for 3 cycles with in_valid=1 -> all outputs 0 and no out_valid. Release, pulse new_round_start -> STAGE_CMD(1) sent to leaf 1, then leaf 2, with out_ready=1.
- LEAF_COUNT=2, leaves answer every poll with {0,0} -> stage sequence 1,2,3,4; iteration_counter=0; a single result_valid pulse; deadlock=0.
- First poll: leaf 2 responds {0,1}, leaf 1 responds {0,0} (out of order). Second poll: both {0,0} -> one extra GROW/MERGE pass; iteration_counter=1 at result_valid.
- Leaf 1 responds {1,0} once -> a second STATUS_REQ round is issued with no GROW and iteration_counter unchanged. Also inject id=3 and id=0 responses -> dropped, no effect.
- Leaves always respond odd, MAX_ITERATIONS=3 -> deadlock=1, iteration_counter=3, result_valid pulses. Hold out_ready low for 5 cycles mid-broadcast -> data and valid held stable throughout.
- STATUS_TIMEOUT_EN defined, POLL_TIMEOUT=16, leaf 2 silent -> deadlock=1 and result_valid 16 cycles after entering POLL_WAIT. Separately, reset asserted during POLL_WAIT -> returns to IDLE with outputs at reset values.
